// File: rtl/ttc3_dus_fuse_loader.sv
// ============================================================================
// Module   : ttc3_dus_fuse_loader
// Brief    : Reads the Device Unique Secret word-by-word from the fuse macro,
//            checks it, then hands it to the DUS storage block once. Optional
//            checksum word read enabled by defining TTC3_DUS_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttc3_dus_fuse_loader #(
    parameter int         DUS_WIDTH      = 256,
    parameter int         WORD_WIDTH     = 32,
    parameter logic [7:0] FUSE_BASE_ADDR = 8'h00,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    output logic                  o_fuse_req,
    output logic [7:0]            o_fuse_addr,
    input  logic                  i_fuse_ack,
    input  logic [WORD_WIDTH-1:0] i_fuse_rdata,
    input  logic                  i_fuse_err,
    input  logic                  i_dus_valid,
    output logic                  o_dus_write_enable,
    output logic [DUS_WIDTH-1:0]  o_dus_write_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [1:0]            o_err_cause
);

    localparam int c_NWORDS = DUS_WIDTH / WORD_WIDTH;
`ifdef TTC3_DUS_CHECKSUM_EN
    localparam int c_NREADS = c_NWORDS + 1;
`else
    localparam int c_NREADS = c_NWORDS;
`endif
    localparam int                c_IDXW     = (c_NREADS > 1) ? $clog2(c_NREADS) : 1;
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_NREADS - 1);
    localparam logic [7:0]        c_TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_GAP   = 3'd2,
        S_CHECK = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            w_cause;
    logic [c_IDXW-1:0]     w_idx_nxt;
    logic                  w_integrity_bad;

    logic [c_IDXW-1:0]     r_idx;
    logic [7:0]            r_tcnt;
    logic [DUS_WIDTH-1:0]  r_secret;
    logic                  r_fuse_req;
    logic [7:0]            r_fuse_addr;
    logic [1:0]            r_cause;

`ifdef TTC3_DUS_CHECKSUM_EN
    localparam logic [c_IDXW-1:0] c_CSUM_IDX = c_IDXW'(c_NWORDS);
    logic [WORD_WIDTH-1:0] r_csum;
    logic [WORD_WIDTH-1:0] w_xor;

    always_comb begin
        w_xor = '0;
        for (int k = 0; k < c_NWORDS; k++) begin
            w_xor = w_xor ^ r_secret[k*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    assign w_integrity_bad = (r_secret == '0) || (r_csum != w_xor);
`else
    assign w_integrity_bad = (r_secret == '0);
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An ack always takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_cause   = 2'd0;
        w_idx_nxt = r_idx;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_dus_valid) begin
                    w_next    = S_FETCH;
                    w_idx_nxt = '0;
                end
            end
            S_FETCH: begin
                if (i_fuse_ack) begin
                    if (i_fuse_err) begin
                        w_next  = S_ERROR;
                        w_cause = 2'd1;
                    end else if (r_idx == c_LAST_IDX) begin
                        w_next = S_CHECK;
                    end else begin
                        w_next = S_GAP;
                    end
                end else if (r_tcnt == c_TO_LAST) begin
                    w_next  = S_ERROR;
                    w_cause = 2'd2;
                end
            end
            S_GAP: begin
                w_next    = S_FETCH;
                w_idx_nxt = r_idx + 1'b1;
            end
            S_CHECK: begin
                if (w_integrity_bad) begin
                    w_next  = S_ERROR;
                    w_cause = 2'd3;
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: w_next = S_DONE;
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_secret    <= '0;
            r_fuse_req  <= 1'b0;
            r_fuse_addr <= 8'h00;
            r_cause     <= 2'd0;
`ifdef TTC3_DUS_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_idx      <= w_idx_nxt;
            r_fuse_req <= (w_next == S_FETCH);
            if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
                r_fuse_addr <= FUSE_BASE_ADDR + {{(8-c_IDXW){1'b0}}, w_idx_nxt};
                r_tcnt      <= 8'h00;
            end else if ((r_state == S_FETCH) && !i_fuse_ack) begin
                r_tcnt <= r_tcnt + 8'h01;
            end
            if ((r_state == S_FETCH) && i_fuse_ack && !i_fuse_err) begin
`ifdef TTC3_DUS_CHECKSUM_EN
                if (r_idx == c_CSUM_IDX) begin
                    r_csum <= i_fuse_rdata;
                end else begin
                    r_secret[int'(r_idx)*WORD_WIDTH +: WORD_WIDTH] <= i_fuse_rdata;
                end
`else
                r_secret[int'(r_idx)*WORD_WIDTH +: WORD_WIDTH] <= i_fuse_rdata;
`endif
            end
            // Scrub last so it overrides any capture on the way out.
            if ((w_next == S_DONE) || (w_next == S_ERROR)) begin
                r_secret <= '0;
`ifdef TTC3_DUS_CHECKSUM_EN
                r_csum   <= '0;
`endif
            end
            if ((w_next == S_ERROR) && (r_state != S_ERROR)) begin
                r_cause <= w_cause;
            end
        end
    end

    assign o_fuse_req         = r_fuse_req;
    assign o_fuse_addr        = r_fuse_addr;
    assign o_dus_write_enable = (r_state == S_WRITE);
    assign o_dus_write_data   = (r_state == S_WRITE) ? r_secret : '0;
    assign o_busy             = (r_state == S_FETCH) || (r_state == S_GAP) ||
                                (r_state == S_CHECK) || (r_state == S_WRITE);
    assign o_done             = (r_state == S_DONE);
    assign o_error            = (r_state == S_ERROR);
    assign o_err_cause        = r_cause;

endmodule

`default_nettype wire

// File: doc/ttc3_dus_fuse_loader.md
# ttc3_dus_fuse_loader

Upstream feeder for the DUS storage block. On a start pulse it reads the 256-bit Device Unique Secret from the OTP/eFuse macro one 32-bit word at a time over a req/ack handshake. It checks integrity, then presents the secret with a single-cycle write strobe to the storage block's one-time write port. The assembly register is scrubbed to zero immediately after the write or on any error, so the secret exists in this block for the minimum number of cycles.

## Interface
- DUS_WIDTH, 256, secret width; must be a multiple of WORD_WIDTH
- WORD_WIDTH, 32, fuse read word width
- FUSE_BASE_ADDR, 8'h00, fuse word address of DUS word 0
- TIMEOUT_CYCLES, 255, max cycles fuse_req may stay high without fuse_ack (8-bit counter)

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a load when idle
- fuse_req  out  1  fuse read request
- fuse_addr  out  8  fuse word address, stable while fuse_req=1
- fuse_ack  in  1  read complete; fuse_rdata/fuse_err valid this cycle
- fuse_rdata  in  WORD_WIDTH  fuse read data
- fuse_err  in  1  uncorrectable fuse read error, qualified by fuse_ack
- dus_valid  in  1  storage block already locked
- dus_write_enable  out  1  one-cycle write strobe to storage
- dus_write_data  out  DUS_WIDTH  secret; driven to zero whenever dus_write_enable=0
- busy  out  1  load in progress
- done  out  1  sticky; secret written
- error  out  1  sticky; load aborted
- err_cause  out  2  1=fuse_err, 2=timeout, 3=integrity (checksum mismatch or all-zero secret)

## Operation
- States: IDLE, FETCH, GAP, CHECK, WRITE, DONE, ERROR.
- IDLE:
  - start=1 and dus_valid=0 → FETCH, word index 0.
  - start is ignored when dus_valid=1 and in every non-IDLE state.
- FETCH:
  - fuse_req=1, fuse_addr=FUSE_BASE_ADDR+index.
  - On a sampled fuse_ack with fuse_err=0: store fuse_rdata into bits [index*32 +: 32] (word 0 → bits [31:0]).
  - After that ack: if more words remain → GAP, else → CHECK.
- GAP: one cycle with fuse_req=0, then → FETCH with index+1.
- fuse_ack with fuse_err=1 → ERROR, cause 1. fuse_err without fuse_ack is ignored.
- Timeout counter:
  - Cleared on FETCH entry; increments each FETCH cycle without ack.
  - Reaching TIMEOUT_CYCLES → ERROR, cause 2.
  - An ack in the same cycle the counter reaches the limit wins.
- CHECK:
  - An all-zero assembled secret → ERROR, cause 3.
  - Otherwise → WRITE.
- WRITE: dus_write_enable=1 and dus_write_data=secret for exactly one cycle, then → DONE.
- DONE:
  - Assembly register cleared to zero on entry.
  - done=1, busy=0.
  - Terminal until reset.
- ERROR:
  - Assembly register cleared to zero.
  - No write strobe is ever issued; fuse_req=0.
  - error=1 with err_cause latched.
  - Terminal until reset.
- busy=1 in FETCH, GAP, CHECK and WRITE.

## Timing
- Reset values: fuse_req=0, fuse_addr=0, dus_write_enable=0, dus_write_data=0, busy=0, done=0, error=0, err_cause=0; assembly register zero; state IDLE.
- Reset assertion mid-load clears everything asynchronously; fuse_req drops without waiting for ack.
- fuse_req is registered and never combinationally depends on fuse_ack.
- fuse_req goes low the cycle after the ack edge.
- Latency with zero-wait fuse (ack in the first FETCH cycle), counted from the clock edge that samples start:
  - FETCH entered at cycle 1.
  - Words 0–6 take 2 cycles each; word 7 takes 1.
  - CHECK at cycle 16, dus_write_enable at cycle 17, done=1 from cycle 18.
  - Each extra ack wait cycle adds 1.
- With TTC3_DUS_CHECKSUM_EN defined, one extra GAP+FETCH pair precedes CHECK: write at cycle 19, done at cycle 20.

## Configuration
- TTC3_DUS_CHECKSUM_EN defined:
  - After the last DUS word, read one extra word at FUSE_BASE_ADDR+DUS_WIDTH/WORD_WIDTH.
  - CHECK requires it to equal the XOR of all DUS words; a mismatch → ERROR, cause 3.
  - The all-zero test still applies.
  - The checksum word is held in a separate register and cleared with the assembly register.
- Undefined: only the DUS words are read; CHECK performs the all-zero test only.

## Test plan
- Nominal load, zero-wait fuse, words 32'h1000_0000+i (i=0..7):
  - dus_write_enable for exactly one cycle at cycle 17, with dus_write_data[31:0]=32'h1000_0000 and [255:224]=32'h1000_0007.
  - done=1 at cycle 18; dus_write_data=0 at all other times.
- fuse_err=1 with ack on word 3:
  - error=1, err_cause=1, no dus_write_enable, fuse_req=0 after.
  - Addresses 0..3 were issued.
- fuse_ack never asserted on word 0:
  - ERROR with err_cause=2 after TIMEOUT_CYCLES=255 request cycles.
  - fuse_req drops; no write.
- All words 32'h0: err_cause=3, no write strobe.
- start with dus_valid=1: stays IDLE; fuse_req never asserts; done=0, error=0.
- reset_n low during word 5 fetch:
  - All outputs return to reset values immediately.
  - A new start afterwards completes normally, beginning at address 0.
- Under TTC3_DUS_CHECKSUM_EN: a checksum word with one bit flipped → err_cause=3, no write; the correct XOR → write at cycle 19.
